// File: rtl/mmss_timer_core_pkg.sv
// timer_pkg: state encoding and time limits shared by the mmss timer blocks
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] MAX_MIN = 6'd59;
  localparam logic [TIME_W-1:0] MAX_SEC = 6'd59;
endpackage

// File: rtl/mmss_timer_core_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-sample debouncer and one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  // cnt tracks consecutive synchronized samples that disagree with the accepted level
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_CYCLES - 1)) cnt <= cnt + 1'b1;
      else begin
        cnt   <= '0;
        level <= sync[1];
        pulse <= sync[1];
      end
    end
endmodule

// File: rtl/mmss_timer_core.sv
// mmss_timer_core: debounced mm:ss up/down timer; AUTO_RELOAD_EN reloads the preset at terminal count
module mmss_timer_core
  import timer_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        sw,
  input  logic [1:0]        btn,
  output logic [TIME_W-1:0] minute,
  output logic [TIME_W-1:0] second,
  output logic              running,
  output logic              done
);
  localparam int PW = $clog2(TICK_DIV + 1);
  state_t state;
  logic start, load, dir, term, unused;
  logic [PW-1:0] psc;
  logic [TIME_W-1:0] clamp, nxt_min, nxt_sec;
`ifdef AUTO_RELOAD_EN
  logic [TIME_W-1:0] preset;
`endif
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (.clk(clk), .rst_n(rst_n), .raw(btn[0]), .pulse(start));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load  (.clk(clk), .rst_n(rst_n), .raw(btn[1]), .pulse(load));
  assign unused = ^{sw[6], CLK_HZ != 0};
  assign clamp = sw[5:0] > MAX_MIN ? MAX_MIN : sw[5:0];
  always_comb begin
    nxt_sec = dir ? (second != '0 ? second - 1'b1 : (minute != '0 ? MAX_SEC : second))
                  : (second < MAX_SEC ? second + 1'b1 : (minute < MAX_MIN ? '0 : second));
    nxt_min = dir ? (second == '0 && minute != '0 ? minute - 1'b1 : minute)
                  : (second == MAX_SEC && minute < MAX_MIN ? minute + 1'b1 : minute);
    term    = dir ? (nxt_min == '0 && nxt_sec == '0) : (nxt_min == MAX_MIN && nxt_sec == MAX_SEC);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= IDLE;
      minute  <= '0;
      second  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      psc     <= '0;
      dir     <= 1'b1;
`ifdef AUTO_RELOAD_EN
      preset  <= '0;
`endif
    end else if (load) begin
      state   <= IDLE;
      minute  <= clamp;
      second  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      psc     <= '0;
      dir     <= sw[7];
`ifdef AUTO_RELOAD_EN
      preset  <= clamp;
`endif
    end else begin
`ifdef AUTO_RELOAD_EN
      if (state != DONE) done <= 1'b0;
`endif
      case (state)
        IDLE:
          if (start) begin
            if (dir && minute == '0 && second == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        RUN:
          if (start) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (psc != PW'(TICK_DIV - 1)) psc <= psc + 1'b1;
          else begin
            psc <= '0;
`ifdef AUTO_RELOAD_EN
            minute <= term ? (dir ? preset : '0) : nxt_min;
            second <= term ? '0 : nxt_sec;
            done   <= term;
`else
            minute <= nxt_min;
            second <= nxt_sec;
            if (term) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
`endif
          end
        PAUSE:
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        default: ;
      endcase
    end
endmodule
